// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter slice.
package alu_arbiter_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int ID_W      = 1;

  localparam logic OP_NAND = 1'b0;
  localparam logic OP_ADD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from the valids.
// Latency: 0 cycles (grant); pointer moves on the cycle after an accept.
// Backpressure: grants nothing while en=0; pointer only moves on upd.
module rr_arb2
  import alu_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      valid,
  input  logic            en,
  input  logic            upd,
  output logic [1:0]      gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic last_grant;

  // On a tie, the requester that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      gnt[0] = valid[0] & (~valid[1] | last_grant);
      gnt[1] = valid[1] & (~valid[0] | ~last_grant);
    end
  end

  assign gnt_id = gnt[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (upd) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters; result tagged with requester id.
// Latency: accept at T, rsp_valid at T+2; one op in flight, peak one op per 3 cycles.
// Backpressure: requests are refused until the response is taken via rsp_ready.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_o,
  input  logic             alu_z,
  input  logic             alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ID_W-1:0]  rsp_id,
  output logic [WIDTH-1:0] rsp_o,
  output logic             rsp_z,
  output logic             rsp_c
);

  state_t          state;
  logic [1:0]      gnt;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] op_id;
  logic            arb_en;
  logic            accept;

  assign arb_en     = (state == ST_IDLE) && !rst;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = |gnt;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .en     (arb_en),
    .upd    (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_id     <= '0;
      alu_op    <= OP_NAND;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_o     <= '0;
      rsp_z     <= 1'b0;
      rsp_c     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_op <= gnt[1] ? req1_op : req0_op;
            alu_a  <= gnt[1] ? req1_a  : req0_a;
            alu_b  <= gnt[1] ? req1_b  : req0_b;
            op_id  <= gnt_id;
            state  <= ST_EXEC;
          end
        end
        // ALU output settles from the operand regs within this cycle.
        ST_EXEC: begin
          rsp_o     <= alu_o;
          rsp_z     <= alu_z;
          rsp_c     <= alu_c;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_op = 1'b0;
  logic [15:0] req0_a = '0, req0_b = '0;
  logic        req1_valid = 1'b0, req1_op = 1'b0;
  logic [15:0] req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready;
  logic        alu_op, alu_z, alu_c;
  logic [15:0] alu_a, alu_b, alu_o;
  logic        rsp_valid, rsp_id, rsp_z, rsp_c;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Shared ALU as the parent would instantiate it.
  always_comb begin
    if (alu_op) begin
      {alu_c, alu_o} = {1'b0, alu_a} + {1'b0, alu_b};
    end else begin
      alu_c = 1'b0;
      alu_o = ~(alu_a & alu_b);
    end
    alu_z = (alu_o == 16'h0000);
  end

  alu_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_o(alu_o), .alu_z(alu_z), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_o(rsp_o), .rsp_z(rsp_z), .rsp_c(rsp_c)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic op, input logic [15:0] a, input logic [15:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic op, input logic [15:0] a, input logic [15:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b1;
    cyc();
    drive0(1'b1, 1'b1, 16'h1111, 16'h2222);
    drive1(1'b1, 1'b1, 16'h3333, 16'h4444);
    #1;
    checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if ({rsp_id, rsp_z, rsp_c} !== 3'b000) begin failures++; $display("FAIL reset_rsp_flags got=%b exp=000", {rsp_id, rsp_z, rsp_c}); end
    checks++; if (rsp_o !== 16'h0000) begin failures++; $display("FAIL reset_rsp_o got=%h exp=0000", rsp_o); end
    checks++; if ({alu_op, alu_a, alu_b} !== 33'h0) begin failures++; $display("FAIL reset_alu_regs got=%h exp=0", {alu_op, alu_a, alu_b}); end
    cyc();
    drive0(1'b0, 1'b0, 16'h0, 16'h0);
    drive1(1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;
  endtask

  task automatic test_add();
    cyc();
    drive0(1'b1, 1'b1, 16'hFFFF, 16'h0001);
    rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL add_req0_ready got=%b exp=1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL add_req1_ready got=%b exp=0", req1_ready); end
    cyc();
    req0_valid = 1'b0;
    #1;
    checks++; if ({alu_op, alu_a, alu_b} !== {1'b1, 16'hFFFF, 16'h0001}) begin failures++; $display("FAIL add_alu_regs got=%h exp=%h", {alu_op, alu_a, alu_b}, {1'b1, 16'hFFFF, 16'h0001}); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_rsp_early got=%b exp=0", rsp_valid); end
    cyc();
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_z, rsp_c} !== 4'b1011) begin failures++; $display("FAIL add_rsp_flags got=%b exp=1011", {rsp_valid, rsp_id, rsp_z, rsp_c}); end
    checks++; if (rsp_o !== 16'h0000) begin failures++; $display("FAIL add_rsp_o got=%h exp=0000", rsp_o); end
    cyc();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_rsp_drop got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_nand();
    cyc();
    drive1(1'b1, 1'b0, 16'h00F0, 16'h0FF0);
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin failures++; $display("FAIL nand1_ready got=%b exp=10", {req1_ready, req0_ready}); end
    cyc();
    req1_valid = 1'b0;
    cyc();
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_z, rsp_c} !== 4'b1100) begin failures++; $display("FAIL nand1_rsp_flags got=%b exp=1100", {rsp_valid, rsp_id, rsp_z, rsp_c}); end
    checks++; if (rsp_o !== 16'hFF0F) begin failures++; $display("FAIL nand1_rsp_o got=%h exp=ff0f", rsp_o); end
    cyc();
    cyc();
    drive1(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    #1;
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL nand2_ready got=%b exp=1", req1_ready); end
    cyc();
    req1_valid = 1'b0;
    cyc();
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_z, rsp_c} !== 4'b1110) begin failures++; $display("FAIL nand2_rsp_flags got=%b exp=1110", {rsp_valid, rsp_id, rsp_z, rsp_c}); end
    checks++; if (rsp_o !== 16'h0000) begin failures++; $display("FAIL nand2_rsp_o got=%h exp=0000", rsp_o); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic        exp_id;
    logic [15:0] exp_o;
    cyc();
    drive0(1'b1, 1'b1, 16'h1234, 16'h4321);
    drive1(1'b1, 1'b1, 16'h8000, 16'h8000);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 1);
      exp_o  = exp_id ? 16'h0000 : 16'h5555;
      #1;
      checks++; if ({req1_ready, req0_ready} !== {exp_id, ~exp_id}) begin failures++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", i, {req1_ready, req0_ready}, {exp_id, ~exp_id}); end
      cyc();
      #1;
      checks++; if ({rsp_valid, req1_ready, req0_ready} !== 3'b000) begin failures++; $display("FAIL b2b_exec[%0d] got=%b exp=000", i, {rsp_valid, req1_ready, req0_ready}); end
      cyc();
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      checks++; if ({rsp_valid, rsp_id, rsp_z, rsp_c} !== {1'b1, exp_id, exp_id, exp_id}) begin failures++; $display("FAIL b2b_rsp_flags[%0d] got=%b exp=%b", i, {rsp_valid, rsp_id, rsp_z, rsp_c}, {1'b1, exp_id, exp_id, exp_id}); end
      checks++; if (rsp_o !== exp_o) begin failures++; $display("FAIL b2b_rsp_o[%0d] got=%h exp=%h", i, rsp_o, exp_o); end
      cyc();
    end
  endtask

  task automatic test_stall();
    cyc();
    drive0(1'b1, 1'b1, 16'h0003, 16'h0004);
    rsp_ready = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL stall_accept got=%b exp=1", req0_ready); end
    cyc();
    req0_valid = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      if (k == 0) drive1(1'b1, 1'b0, 16'h1234, 16'hFFFF);
      if (k == 1) drive0(1'b1, 1'b0, 16'hFFFF, 16'h0000);
      if (k == 2) req0_valid = 1'b0;
      #1;
      checks++; if ({rsp_valid, rsp_id, rsp_o, req1_ready, req0_ready} !== {1'b1, 1'b0, 16'h0007, 2'b00}) begin failures++; $display("FAIL stall_hold[%0d] got=%h exp=%h", k, {rsp_valid, rsp_id, rsp_o, req1_ready, req0_ready}, {1'b1, 1'b0, 16'h0007, 2'b00}); end
      checks++; if ({alu_op, alu_a, alu_b} !== {1'b1, 16'h0003, 16'h0004}) begin failures++; $display("FAIL stall_operands[%0d] got=%h exp=%h", k, {alu_op, alu_a, alu_b}, {1'b1, 16'h0003, 16'h0004}); end
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if ({rsp_valid, req1_ready} !== 2'b10) begin failures++; $display("FAIL stall_release got=%b exp=10", {rsp_valid, req1_ready}); end
    cyc();
    #1;
    checks++; if ({rsp_valid, req1_ready, req0_ready} !== 3'b010) begin failures++; $display("FAIL stall_next_accept got=%b exp=010", {rsp_valid, req1_ready, req0_ready}); end
    cyc();
    req1_valid = 1'b0;
    cyc();
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_z, rsp_c, rsp_o} !== {4'b1100, 16'hEDCB}) begin failures++; $display("FAIL stall_next_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_z, rsp_c, rsp_o}, {4'b1100, 16'hEDCB}); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_phantom[%0d] got=%b exp=0", k, rsp_valid); end
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    drive1(1'b1, 1'b1, 16'h0001, 16'h0002);
    rsp_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL rmid_accept got=%b exp=1", req1_ready); end
    cyc();
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if ({rsp_valid, alu_op, alu_a, alu_b} !== 34'h0) begin failures++; $display("FAIL rmid_clear got=%h exp=0", {rsp_valid, alu_op, alu_a, alu_b}); end
    cyc();
    drive0(1'b1, 1'b1, 16'h0100, 16'h0011);
    drive1(1'b1, 1'b1, 16'h0001, 16'h0002);
    #1;
    checks++; if ({rsp_valid, req1_ready, req0_ready} !== 3'b000) begin failures++; $display("FAIL rmid_in_reset got=%b exp=000", {rsp_valid, req1_ready, req0_ready}); end
    cyc();
    rst = 1'b0;
    #1;
    checks++; if ({rsp_valid, req1_ready, req0_ready} !== 3'b001) begin failures++; $display("FAIL rmid_first_grant got=%b exp=001", {rsp_valid, req1_ready, req0_ready}); end
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_stale_rsp got=%b exp=0", rsp_valid); end
    cyc();
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_z, rsp_c, rsp_o} !== {4'b1000, 16'h0111}) begin failures++; $display("FAIL rmid_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_z, rsp_c, rsp_o}, {4'b1000, 16'h0111}); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_add();
    test_nand();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 16-bit ALU instance (op=1 ADD with carry-out, op=0 NAND, zero flag) between two requesters.
- Round-robin arbitration; operands registered before the ALU, result and flags registered after it.
- Single response channel tagged with requester id, valid/ready backpressure.
- Sits between the two issuing units and the shared ALU. The parent instantiates the ALU and wires it to the alu_* ports.

Parameters:
WIDTH, 16, datapath width of operands and result

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  1  1=ADD, 0=NAND
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0
alu_op  out  1  op to shared ALU (registered)
alu_a  out  WIDTH  operand A to ALU (registered)
alu_b  out  WIDTH  operand B to ALU (registered)
alu_o  in  WIDTH  ALU result
alu_z  in  1  ALU zero flag
alu_c  in  1  ALU carry flag (0 for NAND)
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester id of response
rsp_o  out  WIDTH  result
rsp_z  out  1  zero flag
rsp_c  out  1  carry flag

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed from the valids.
  - reqN_ready=1 only for the granted requester, and only when its valid=1.
  - On accept: latch op/a/b into the operand regs, latch the grant id, go to EXEC.
- EXEC (one cycle): the ALU evaluates the operand regs combinationally. At the end of the cycle, capture alu_o/alu_z/alu_c and the id into the response regs, then go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* held stable.
  - On rsp_valid&rsp_ready, go to IDLE. No request is accepted in that same cycle.
- Latency: accept at cycle T, rsp_valid rises at T+2. Peak throughput is one op per 3 cycles.
- reqN_ready=0 in EXEC and RESP, and forced 0 while rst=1.
- Round-robin pointer last_grant, reset to 1, so req0 wins the first tie.
  - Both valid: grant ~last_grant.
  - Single valid: grant it.
  - last_grant updates only on accept.
- A requester dropping valid without ready is legal and no state changes. Operands are sampled only on the accept cycle.
- Carry and zero come solely from the ALU. The arbiter performs no arithmetic and no width extension.
- Reset values:
  - state=IDLE, last_grant=1.
  - alu_op=0, alu_a=0, alu_b=0.
  - rsp_valid=0, rsp_id=0, rsp_o=0, rsp_z=0, rsp_c=0.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded and no response is produced. The next grant obeys the reset pointer.
- rsp_ready high while rsp_valid=0 is ignored.

Decomposition:
- Shared package:
  - WIDTH default.
  - ALU op constants OP_NAND=0, OP_ADD=1.
  - FSM state encoding ST_IDLE, ST_EXEC, ST_RESP.
  - Requester id width (1).
- One natural sub-module, rr_arb2:
  - Inputs: two valids, an enable, and a pointer update on accept.
  - Outputs: a one-hot grant and the grant id.
  - Holds last_grant, with async reset to 1.
- The FSM, operand regs and response regs stay in alu_arbiter.

Test Plan:
- Reset, then req0 ADD a=0xFFFF b=0x0001 with rsp_ready=1 -> req0_ready at T, alu_a=0xFFFF at T+1, rsp_valid at T+2 with id=0 o=0x0000 z=1 c=1.
- req1 NAND a=0x00F0 b=0x0FF0 -> rsp id=1 o=0xFF0F z=0 c=0. Then req1 NAND 0xFFFF,0xFFFF -> o=0x0000 z=1 c=0.
- Both valid continuously, rsp_ready=1, 4 ops (req0 ADD 0x1234+0x4321, req1 ADD 0x8000+0x8000, ...) -> grant order 0,1,0,1. Responses 0x5555 c=0 z=0, then 0x0000 c=1 z=1. Responses are 3 cycles apart.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, both reqN_ready=0. On rsp_ready=1, return to IDLE, with the next accept one cycle later.
- Assert rst during EXEC of a req1 op -> rsp_valid stays 0 and all outputs take reset values. After release with both valid, req0 is granted first.
- req0 valid pulses one cycle with no grant, because the FSM is busy -> no state change, no phantom response.
